// File: rtl/vga_capture.sv
// Captures a 2x-decimated window of a VGA source stream and queues RGB565 writes to VRAM.
// The frame-level FSM arms on enable, captures between vsync falling edges and drains the queue.
module vga_capture #(
    parameter int H_OUT      = 320,
    parameter int V_OUT      = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_vga_r,
    input  logic [7:0]  i_vga_g,
    input  logic [7:0]  i_vga_b,
    input  logic        i_vga_blank_n,
    input  logic        i_vga_vs,
    input  logic        i_enable,
    input  logic [17:0] i_capture_offset,
    output logic [17:0] o_address,
    output logic [15:0] o_pixel,
    output logic        o_we,
    input  logic        i_ready,
    output logic        o_frame_done,
    output logic        o_overflow,
    output logic        o_busy
);

    localparam int CW   = $clog2(2 * H_OUT) + 1;
    localparam int LW   = $clog2(2 * V_OUT) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN} state_t;

    state_t           r_state, w_state_next;
    logic             r_vs_prev, r_blank_prev;
    logic [CW-1:0]    r_col;
    logic [LW-1:0]    r_line;
    logic [17:0]      r_offset;
    logic             r_complete, r_overflow, r_frame_done;
    logic [33:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_rd, r_wr;
    logic [CNTW-1:0]  r_count;
    logic             r_we;
    logic [17:0]      r_address;
    logic [15:0]      r_pixel;

    logic             w_vs_fall, w_blank_fall, w_line_full, w_start;
    logic             w_capturing, w_drain_empty, w_busy;
    logic             w_sample, w_pop, w_push, w_drop;
    logic [17:0]      w_addr, w_row, w_colh;
    logic [15:0]      w_pix;
    logic [AW-1:0]    w_rd_next;
    logic [CNTW-1:0]  w_remain;
    logic             w_unused_bits;

    assign w_vs_fall    = r_vs_prev & ~i_vga_vs;
    assign w_blank_fall = r_blank_prev & ~i_vga_blank_n;
    assign w_line_full  = (r_line == LW'(2 * V_OUT));
    assign w_start      = (r_state == S_ARM) && (w_state_next == S_CAPTURE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (i_enable) w_state_next = S_ARM;
            S_ARM:     if (!i_enable) w_state_next = S_IDLE;
                       else if (w_vs_fall) w_state_next = S_CAPTURE;
            S_CAPTURE: if (w_line_full || w_vs_fall || !i_enable) w_state_next = S_DRAIN;
            S_DRAIN:   if (r_count == '0) w_state_next = i_enable ? S_ARM : S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_capturing   = (r_state == S_CAPTURE);
        w_drain_empty = (r_state == S_DRAIN) && (r_count == '0);
        w_busy        = (r_state != S_IDLE);
    end

    // Only even source pixels on even source lines inside the output window are kept.
    assign w_sample = w_capturing && i_vga_blank_n && !r_line[0] && !r_col[0]
                      && (r_col < CW'(2 * H_OUT)) && (r_line < LW'(2 * V_OUT));
    assign w_row    = 18'(r_line >> 1);
    assign w_colh   = 18'(r_col >> 1);
    assign w_addr   = r_offset + w_row * 18'(H_OUT) + w_colh;
    assign w_pix    = {i_vga_r[7:3], i_vga_g[7:2], i_vga_b[7:3]};
    assign w_unused_bits = ^{i_vga_r[2:0], i_vga_g[1:0], i_vga_b[2:0]};

    // A full queue still takes a new sample when the head leaves in the same cycle.
    assign w_pop     = r_we & i_ready;
    assign w_push    = w_sample && ((r_count != CNTW'(FIFO_DEPTH)) || w_pop);
    assign w_drop    = w_sample && !w_push;
    assign w_rd_next = r_rd + AW'(w_pop);
    assign w_remain  = r_count - CNTW'(w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vs_prev    <= 1'b0;
            r_blank_prev <= 1'b0;
            r_col        <= '0;
            r_line       <= '0;
            r_offset     <= '0;
            r_complete   <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vs_prev    <= i_vga_vs;
            r_blank_prev <= i_vga_blank_n;
            r_frame_done <= w_drain_empty && r_complete;
            if (w_start) begin
                r_col      <= '0;
                r_line     <= '0;
                r_offset   <= i_capture_offset;
                r_complete <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_capturing) begin
                    if (!i_vga_blank_n)   r_col <= '0;
                    else if (r_col != '1) r_col <= r_col + CW'(1);
                    if (w_blank_fall)     r_line <= r_line + LW'(1);
                    if (w_line_full)      r_complete <= 1'b1;
                end
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= {w_addr, w_pix};
    end

    // The count includes the entry presented on the outputs until it is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_address <= '0;
            r_pixel   <= '0;
        end else begin
            r_rd    <= w_rd_next;
            r_wr    <= r_wr + AW'(w_push);
            r_count <= w_remain + CNTW'(w_push);
            r_we    <= (w_remain != '0);
            if (w_remain != '0) {r_address, r_pixel} <= r_mem[w_rd_next];
        end
    end

    assign o_we         = r_we;
    assign o_address    = r_address;
    assign o_pixel      = r_pixel;
    assign o_frame_done = r_frame_done;
    assign o_overflow   = r_overflow;
    assign o_busy       = w_busy;

endmodule
